// File: rtl/wait_queue_pkg.sv
// Shared definitions for the wait_queue command buffer: FSM state encodings
// and default FIFO geometry.
package wait_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/wait_queue_if.sv
// Control-unit request handshake plus WAIT-unit command/status signals.
// slave: the wait_queue side; master: control unit and WAIT unit side.
interface wait_queue_if #(
  parameter int AW = wait_queue_pkg::DEFAULT_AW
);
  logic          req_valid;
  logic [7:0]    req_data;
  logic          req_ready;
  logic          flush;
  logic [7:0]    wait_din;
  logic          wait_start;
  logic          wait_busy;
  logic [AW:0]   count;
  logic          idle;

  modport slave (
    input  req_valid, req_data, flush, wait_busy,
    output req_ready, wait_din, wait_start, count, idle
  );

  modport master (
    output req_valid, req_data, flush, wait_busy,
    input  req_ready, wait_din, wait_start, count, idle
  );
endinterface

// File: rtl/wait_fifo.sv
// Byte FIFO with occupancy count and synchronous flush; push is ignored when
// full or flushing, pop is ignored when empty or flushing.
module wait_fifo
  import wait_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (flush_i)                count_d = '0;
    else if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/wait_queue.sv
// Queues wait requests and issues them one at a time to the WAIT unit,
// tracking its busy. Define WAITQ_SKIPZERO_EN to drop zero-count requests.
module wait_queue
  import wait_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  wait_queue_if.slave   bus
);

  state_e      state_q, state_d;
  logic [7:0]  wait_din_q, wait_din_d;
  logic        wait_start_q, wait_start_d;
  logic        push, pop, full, empty;
  logic [7:0]  head;
  logic [AW:0] count;

  assign bus.req_ready = !full;

`ifdef WAITQ_SKIPZERO_EN
  // Zero requests complete the handshake but never occupy an entry.
  assign push = bus.req_valid && bus.req_ready && (bus.req_data != 8'd0);
`else
  assign push = bus.req_valid && bus.req_ready;
`endif

  wait_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.req_data),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    wait_din_d   = wait_din_q;
    wait_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.flush) begin
          state_d      = ISSUE;
          pop          = 1'b1;
          wait_din_d   = head;
          wait_start_d = 1'b1;
        end
      end
      ISSUE: state_d = ARM;
      // WAIT shows busy one cycle after start, so it is first sampled here.
      ARM:   state_d = bus.wait_busy ? HOLD : IDLE;
      HOLD:  if (!bus.wait_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_din_q   <= 8'd0;
      wait_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_din_q   <= wait_din_d;
      wait_start_q <= wait_start_d;
    end
  end

  assign bus.wait_din   = wait_din_q;
  assign bus.wait_start = wait_start_q;
  assign bus.count      = count;
  assign bus.idle       = empty && (state_q == IDLE);

endmodule
